// File: rtl/efpga_copro_unit.sv
// efpga_copro_unit: responder for the EFPGA0/EFPGA1 custom instructions.
// It accepts one request from execute, starts the eFPGA fabric, waits for
// done or a bounded timeout, and holds the response until writeback takes it.
module efpga_copro_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            p_clk,
  input  logic            p_reset,
  input  logic            p_req_valid,
  output logic            p_req_ready,
  input  logic [2:0]      p_req_funct3,
  input  logic [6:0]      p_req_funct7,
  input  logic [XLEN-1:0] p_req_rs1,
  input  logic [XLEN-1:0] p_req_rs2,
  input  logic [4:0]      p_req_rd,
  input  logic            p_flush,
  output logic            p_rsp_valid,
  input  logic            p_rsp_ready,
  output logic [XLEN-1:0] p_rsp_data,
  output logic [4:0]      p_rsp_rd,
  output logic            p_rsp_err,
  output logic            p_fab_start,
  output logic            p_fab_abort,
  output logic [7:0]      p_fab_op,
  output logic [XLEN-1:0] p_fab_a,
  output logic [XLEN-1:0] p_fab_b,
  input  logic            p_fab_done,
  input  logic [XLEN-1:0] p_fab_result
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              start_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic [4:0]        rsp_rd_q;
  logic [7:0]        fab_op_q;
  logic [XLEN-1:0]   fab_a_q;
  logic [XLEN-1:0]   fab_b_q;

  logic accept;
  logic legal;
  logic timeout_hit;

  // Ready is qualified by reset and flush so it drops immediately, without
  // waiting for a clock edge.
  assign p_req_ready = (state_q == S_IDLE) && p_reset && !p_flush;
  assign accept      = p_req_valid && p_req_ready;
  assign legal       = (p_req_funct3[2:1] == 2'b11);
  assign timeout_hit = (state_q == S_WAIT) && !p_fab_done &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Abort has to land in the same cycle as the flush or the final WAIT cycle,
  // so it is decoded from the current state rather than registered.
  assign p_fab_abort = p_flush ? ((state_q == S_ISSUE) || (state_q == S_WAIT))
                               : timeout_hit;

  assign p_fab_start = start_q;
  assign p_rsp_valid = rsp_valid_q;
  assign p_rsp_err   = rsp_err_q;
  assign p_rsp_data  = rsp_data_q;
  assign p_rsp_rd    = rsp_rd_q;
  assign p_fab_op    = fab_op_q;
  assign p_fab_a     = fab_a_q;
  assign p_fab_b     = fab_b_q;

  // Control FSM with all registered outputs, timeout counter and latches.
  always_ff @(posedge p_clk or negedge p_reset) begin
    if (!p_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      fab_op_q    <= '0;
      fab_a_q     <= '0;
      fab_b_q     <= '0;
    end else begin
      start_q <= 1'b0;
      if (p_flush && (state_q != S_IDLE)) begin
        state_q     <= S_IDLE;
        rsp_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (accept) begin
              rsp_rd_q <= p_req_rd;
              if (legal) begin
                fab_op_q <= {p_req_funct3[0], p_req_funct7};
                fab_a_q  <= p_req_rs1;
                fab_b_q  <= p_req_rs2;
                start_q  <= 1'b1;
                state_q  <= S_ISSUE;
              end else begin
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
            end
          end
          S_ISSUE: begin
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (p_fab_done) begin
              rsp_data_q  <= p_fab_result;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else if (timeout_hit) begin
              rsp_data_q  <= '1;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_RESP: begin
            if (p_rsp_ready) begin
              rsp_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_efpga_copro_unit.sv
// Self-checking bench for efpga_copro_unit: directed test-plan cases plus
// randomized transactions compared against a transaction-level model.
module tb_efpga_copro_unit;

  localparam int XLEN = 32;
  localparam int TMO  = 8;

  logic            p_clk;
  logic            p_reset;
  logic            p_req_valid;
  logic            p_req_ready;
  logic [2:0]      p_req_funct3;
  logic [6:0]      p_req_funct7;
  logic [XLEN-1:0] p_req_rs1;
  logic [XLEN-1:0] p_req_rs2;
  logic [4:0]      p_req_rd;
  logic            p_flush;
  logic            p_rsp_valid;
  logic            p_rsp_ready;
  logic [XLEN-1:0] p_rsp_data;
  logic [4:0]      p_rsp_rd;
  logic            p_rsp_err;
  logic            p_fab_start;
  logic            p_fab_abort;
  logic [7:0]      p_fab_op;
  logic [XLEN-1:0] p_fab_a;
  logic [XLEN-1:0] p_fab_b;
  logic            p_fab_done;
  logic [XLEN-1:0] p_fab_result;

  efpga_copro_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .p_req_valid(p_req_valid), .p_req_ready(p_req_ready),
    .p_req_funct3(p_req_funct3), .p_req_funct7(p_req_funct7),
    .p_req_rs1(p_req_rs1), .p_req_rs2(p_req_rs2), .p_req_rd(p_req_rd),
    .p_flush(p_flush),
    .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready),
    .p_rsp_data(p_rsp_data), .p_rsp_rd(p_rsp_rd), .p_rsp_err(p_rsp_err),
    .p_fab_start(p_fab_start), .p_fab_abort(p_fab_abort),
    .p_fab_op(p_fab_op), .p_fab_a(p_fab_a), .p_fab_b(p_fab_b),
    .p_fab_done(p_fab_done), .p_fab_result(p_fab_result)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 4 units later, mid-cycle.
  task automatic next_cycle();
    @(posedge p_clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", p_req_ready, 0);
    check("rst_rsp_valid", p_rsp_valid, 0);
    check("rst_rsp_data",  p_rsp_data, 0);
    check("rst_rsp_rd",    p_rsp_rd, 0);
    check("rst_rsp_err",   p_rsp_err, 0);
    check("rst_fab_start", p_fab_start, 0);
    check("rst_fab_abort", p_fab_abort, 0);
    check("rst_fab_op",    p_fab_op, 0);
    check("rst_fab_a",     p_fab_a, 0);
    check("rst_fab_b",     p_fab_b, 0);
  endtask

  // Issue a request (entered at edge+1, ready must be seen high).
  task automatic send_req(input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    p_req_valid  = 1'b1;
    p_req_funct3 = f3;
    p_req_funct7 = f7;
    p_req_rs1    = a;
    p_req_rs2    = b;
    p_req_rd     = rd;
    #4;
    check("req_ready", p_req_ready, 1);
    next_cycle();
    p_req_valid = 1'b0;
  endtask

  // One full transaction. d = WAIT cycle (1-based) in which the fabric pulses
  // done; anything above TMO means the fabric never answers in time.
  task automatic run_op(input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int d,
                        input logic [31:0] res, input bit spur, input int stall);
    bit          legal    = (f3 == 3'b110) || (f3 == 3'b111);
    bit          exp_to   = legal && (d > TMO);
    int          exp_lat  = !legal ? 1 : (exp_to ? TMO + 2 : d + 2);
    logic [31:0] exp_data = !legal ? 32'h0 : (exp_to ? 32'hFFFF_FFFF : res);
    bit          exp_err  = !legal || exp_to;
    logic [7:0]  exp_op   = {f3[0], f7};
    int starts = 0, start_n = -1, aborts = 0, abort_n = -1, lat = -1;

    p_rsp_ready = 1'b0;
    send_req(f3, f7, a, b, rd);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      // Cycle 1 after accept is ISSUE; WAIT cycle k is cycle k+1.
      p_fab_done   = (legal && (n == d + 1)) || (spur && n == 1);
      p_fab_result = (n == 1) ? ~res : res;
      #4;
      if (n == 1) check("req_ready_busy", p_req_ready, 0);
      if (p_fab_start) begin
        starts++;
        start_n = n;
        check("fab_op", p_fab_op, exp_op);
        check("fab_a",  p_fab_a, a);
        check("fab_b",  p_fab_b, b);
      end
      if (p_fab_abort) begin
        aborts++;
        abort_n = n;
      end
      if (p_rsp_valid) lat = n;
      else next_cycle();
    end
    p_fab_done = 1'b0;
    if (lat < 0) begin
      check("rsp_never_valid", 0, 1);
      p_reset = 1'b0;
      #2;
      p_reset = 1'b1;
      next_cycle();
      return;
    end
    check("rsp_latency", lat, exp_lat);
    check("start_count", starts, legal ? 1 : 0);
    if (legal) check("start_cycle", start_n, 1);
    check("abort_count", aborts, exp_to ? 1 : 0);
    if (exp_to) check("abort_cycle", abort_n, TMO + 1);
    check("rsp_data", p_rsp_data, exp_data);
    check("rsp_rd",   p_rsp_rd, rd);
    check("rsp_err",  p_rsp_err, exp_err);
    for (int s = 0; s < stall; s++) begin
      next_cycle();
      #4;
      check("stall_valid", p_rsp_valid, 1);
      check("stall_data",  p_rsp_data, exp_data);
      check("stall_rd",    p_rsp_rd, rd);
      check("stall_err",   p_rsp_err, exp_err);
      check("stall_ready", p_req_ready, 0);
    end
    p_rsp_ready = 1'b1;
    next_cycle();
    p_rsp_ready = 1'b0;
    #4;
    check("post_rsp_valid", p_rsp_valid, 0);
    check("post_req_ready", p_req_ready, 1);
    next_cycle();
  endtask

  initial begin
    p_reset = 1'b0; p_req_valid = 1'b0; p_req_funct3 = '0; p_req_funct7 = '0;
    p_req_rs1 = '0; p_req_rs2 = '0; p_req_rd = '0; p_flush = 1'b0;
    p_rsp_ready = 1'b0; p_fab_done = 1'b0; p_fab_result = '0;

    // Reset values
    next_cycle();
    next_cycle();
    #4;
    check_reset_outputs();
    next_cycle();
    p_reset = 1'b1;
    #4;
    check("ready_after_reset", p_req_ready, 1);
    next_cycle();

    // Test-plan transactions
    run_op(3'b110, 7'h05, 32'h10, 32'h20, 5'd3, 4, 32'h30, 1'b0, 0);
    run_op(3'b111, 7'h7F, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, 2, 32'hCAFE_F00D, 1'b0, 5);
    run_op(3'b000, 7'h11, 32'h1, 32'h2, 5'd9, 1, 32'h55, 1'b0, 1);
    run_op(3'b110, 7'h01, 32'h3, 32'h4, 5'd1, 100, 32'h77, 1'b0, 0);
    run_op(3'b110, 7'h02, 32'h5, 32'h6, 5'd2, TMO, 32'hABCD, 1'b0, 0);
    run_op(3'b111, 7'h03, 32'h7, 32'h8, 5'd4, TMO + 1, 32'h9999, 1'b0, 0);
    run_op(3'b111, 7'h04, 32'h9, 32'hA, 5'd5, 1, 32'h4242, 1'b1, 2);

    // Flush while waiting: abort, back to IDLE, no response
    send_req(3'b110, 7'h0A, 32'h11, 32'h22, 5'd7);
    next_cycle();
    next_cycle();
    p_flush = 1'b1;
    #4;
    check("flush_abort", p_fab_abort, 1);
    check("flush_ready", p_req_ready, 0);
    next_cycle();
    p_flush = 1'b0;
    #4;
    check("flush_idle_ready", p_req_ready, 1);
    check("flush_no_rsp", p_rsp_valid, 0);
    check("flush_abort_once", p_fab_abort, 0);
    next_cycle();
    // Flush in IDLE blocks a simultaneous request
    p_flush = 1'b1;
    p_req_valid = 1'b1;
    p_req_funct3 = 3'b110;
    #4;
    check("flush_idle_block", p_req_ready, 0);
    next_cycle();
    p_flush = 1'b0;
    p_req_valid = 1'b0;
    #4;
    check("flush_idle_no_start", p_fab_start, 0);
    check("flush_idle_no_rsp", p_rsp_valid, 0);
    next_cycle();
    run_op(3'b111, 7'h2B, 32'h100, 32'h200, 5'd12, 3, 32'h300, 1'b0, 0);

    // Reset asserted in WAIT
    send_req(3'b110, 7'h0C, 32'hAA, 32'hBB, 5'd8);
    next_cycle();
    next_cycle();
    #4;
    p_reset = 1'b0;
    #1;
    check_reset_outputs();
    next_cycle();
    p_reset = 1'b1;
    next_cycle();
    run_op(3'b110, 7'h0D, 32'h1, 32'h1, 5'd2, 5, 32'h2, 1'b0, 0);

    // Reset asserted in RESP
    send_req(3'b111, 7'h0E, 32'hCC, 32'hDD, 5'd30);
    next_cycle();
    p_fab_done = 1'b1;
    p_fab_result = 32'h1357;
    next_cycle();
    p_fab_done = 1'b0;
    #4;
    check("resp_before_reset", p_rsp_valid, 1);
    p_reset = 1'b0;
    #1;
    check_reset_outputs();
    next_cycle();
    p_reset = 1'b1;
    next_cycle();
    run_op(3'b111, 7'h0F, 32'h5, 32'h6, 5'd6, 1, 32'hB, 1'b0, 0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5))
                                       : {2'b11, 1'($urandom_range(0, 1))};
      run_op(f3, 7'($urandom), $urandom, $urandom, 5'($urandom),
             int'($urandom_range(1, TMO + 3)), $urandom,
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
